// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module   : fetch_sequencer
// Brief    : PC owner for instruction fetch with kill bubble and return stack.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          RAS_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             hold,
    input  logic                             redir_valid,
    input  logic [15:0]                      redir_target,
    input  logic                             call_valid,
    input  logic                             ret_valid,
    output logic [15:0]                      imem_addr,
    output logic                             imem_stall,
    output logic                             fetch_valid,
    output logic [15:0]                      fetch_pc,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_underflow
);

    localparam int c_cnt_w = $clog2(RAS_DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_ras_full = c_cnt_w'(RAS_DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_KILL = 2'd2
    } state_t;

    state_t               r_state, w_state_next;
    logic [15:0]          r_pc, w_pc_next;
    logic [15:0]          r_fetch_pc, w_fetch_pc_next;
    logic                 r_fetch_valid, w_fetch_valid_next;
    logic                 r_underflow, w_underflow_next;
    logic [c_cnt_w-1:0]   r_ras_count, w_ras_count_next;
    logic [15:0]          r_ras [RAS_DEPTH];
    logic [15:0]          w_ras_next [RAS_DEPTH];
    logic [15:0]          w_ras_top;
    logic [15:0]          w_link;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC;
            r_fetch_pc    <= 16'h0000;
            r_fetch_valid <= 1'b0;
            r_underflow   <= 1'b0;
            r_ras_count   <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= 16'h0000;
            end
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_fetch_pc    <= w_fetch_pc_next;
            r_fetch_valid <= w_fetch_valid_next;
            r_underflow   <= w_underflow_next;
            r_ras_count   <= w_ras_count_next;
            r_ras         <= w_ras_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_fetch_pc_next    = r_fetch_pc;
        w_fetch_valid_next = r_fetch_valid;
        w_underflow_next   = 1'b0;
        w_ras_count_next   = r_ras_count;
        w_ras_next         = r_ras;
        w_link             = r_fetch_pc + 16'd1;
        w_ras_top          = 16'h0000;

        // Stack grows upward; the top lives at index count-1.
        for (int i = 0; i < RAS_DEPTH; i++) begin
            if (r_ras_count == c_cnt_w'(i + 1)) begin
                w_ras_top = r_ras[i];
            end
        end

        if (!hold) begin
            // The instruction at pc is captured by memory on every unstalled edge.
            w_fetch_pc_next = r_pc;
            case (r_state)
                ST_BOOT, ST_KILL: begin
                    w_pc_next          = r_pc + 16'd1;
                    w_fetch_valid_next = 1'b1;
                    w_state_next       = ST_RUN;
                end
                ST_RUN: begin
                    if (r_fetch_valid && redir_valid) begin
                        w_pc_next          = redir_target;
                        w_fetch_valid_next = 1'b0;
                        w_state_next       = ST_KILL;
                        if (call_valid) begin
                            if (r_ras_count == c_ras_full) begin
                                for (int i = 0; i < RAS_DEPTH - 1; i++) begin
                                    w_ras_next[i] = r_ras[i + 1];
                                end
                                w_ras_next[RAS_DEPTH-1] = w_link;
                            end else begin
                                for (int i = 0; i < RAS_DEPTH; i++) begin
                                    if (r_ras_count == c_cnt_w'(i)) begin
                                        w_ras_next[i] = w_link;
                                    end
                                end
                                w_ras_count_next = r_ras_count + 1'b1;
                            end
                        end
                    end else if (r_fetch_valid && ret_valid) begin
                        w_fetch_valid_next = 1'b0;
                        w_state_next       = ST_KILL;
                        if (r_ras_count == '0) begin
                            w_pc_next        = 16'h0000;
                            w_underflow_next = 1'b1;
                        end else begin
                            w_pc_next        = w_ras_top;
                            w_ras_count_next = r_ras_count - 1'b1;
                        end
                    end else begin
                        w_pc_next          = r_pc + 16'd1;
                        w_fetch_valid_next = 1'b1;
                    end
                end
                default: begin
                    w_state_next       = ST_BOOT;
                    w_fetch_valid_next = 1'b0;
                end
            endcase
        end
    end

    assign imem_addr     = r_pc;
    assign imem_stall    = hold;
    assign fetch_valid   = r_fetch_valid;
    assign fetch_pc      = r_fetch_pc;
    assign ras_count     = r_ras_count;
    assign ras_underflow = r_underflow;

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Drives the instruction memory. Owns the PC, generates the memory address and stall, and tags the memory output with its PC and a valid bit.
- Inserts the one-cycle kill bubble after a taken branch, jump or return.
- Provides a return-address stack (RAS) for call/return.
- Sits between the instruction memory and the decode stage; the memory output register acts as the IF/ID instruction register.

Parameters:
- RESET_PC, 16'h0000, PC loaded on reset.
- RAS_DEPTH, 4, number of RAS entries (≥2).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- hold  in  1  decode/hazard stall; freezes fetch.
- redir_valid  in  1  taken branch/jump resolved on the instruction currently at memory output.
- redir_target  in  16  redirect target address.
- call_valid  in  1  with redir_valid: also push link (fetch_pc+1) onto RAS.
- ret_valid  in  1  return: redirect to popped RAS top.
- imem_addr  out  16  address to instruction memory (registered PC).
- imem_stall  out  1  stall to instruction memory; equals hold.
- fetch_valid  out  1  memory output holds a valid, non-killed instruction.
- fetch_pc  out  16  PC of the instruction at memory output.
- ras_count  out  clog2(RAS_DEPTH+1)  current RAS occupancy.
- ras_underflow  out  1  one-cycle pulse: return with empty RAS.

Behaviour:
- Memory contract: the memory captures instMemory[imem_addr] on a rising edge when imem_stall=0. Read latency is 1 cycle.
- imem_addr = pc register, with no combinational path from inputs. imem_stall = hold combinationally, in all states.
- Reset (rst_n=0 at edge):
  - pc=RESET_PC, fetch_pc=0, fetch_valid=0, state=BOOT.
  - RAS emptied (ras_count=0), ras_underflow=0.
  - Reset overrides every other input.
- States: BOOT, RUN, KILL.
- When hold=1, the state, pc, fetch_pc, fetch_valid and RAS all hold, and ras_underflow=0. Every transition below applies only when hold=0.
- BOOT:
  - fetch_valid=0.
  - Edge: fetch_pc<=pc, pc<=pc+1, fetch_valid<=1, go to RUN.
  - Redirect inputs are ignored.
- RUN, no event:
  - fetch_pc<=pc, pc<=pc+1, fetch_valid<=1.
- RUN with a redirect event (redir_valid or ret_valid, fetch_valid=1):
  - fetch_pc<=pc (wrong-path instruction being captured), fetch_valid<=0, go to KILL.
  - pc<=redir_target, or RAS top for a return.
- KILL:
  - fetch_valid=0; all redirect inputs are ignored.
  - Edge: fetch_pc<=pc, pc<=pc+1, fetch_valid<=1, go to RUN.
  - Exactly one bubble per redirect.
- Priority: redir_valid over ret_valid; when both are asserted, the return is ignored (no pop).
- call_valid without redir_valid is ignored.
- Call (redir_valid & call_valid):
  - Push fetch_pc+1 (16-bit wrap).
  - If full: oldest entry is discarded, new entry becomes top, ras_count stays RAS_DEPTH.
- Return (ret_valid only):
  - Pop the top; it becomes the target.
  - If empty: target=16'h0000, ras_count stays 0, ras_underflow=1 for that cycle; the redirect and bubble still occur.
- Arithmetic: all PC math is 16-bit modulo; 16'hFFFF+1 = 16'h0000.
- ras_underflow is registered and asserted for exactly the cycle following the offending edge; otherwise 0.

Test Plan:
- Reset + sequential, RESET_PC=0, hold=0 → imem_addr 0,1,2,3…; fetch_valid 0 for one cycle, then 1 with fetch_pc 0,1,2…
- Branch: redir_valid, target=12, while fetch_pc=3 valid → next cycle fetch_valid=0, fetch_pc=4; then fetch_valid=1 with fetch_pc=12, 13.
- Hold: hold=1 for 2 cycles at fetch_pc=2, imem_addr=3 → imem_stall=1, all outputs frozen. Release → fetch_pc=3, no lost or duplicated PC.
- Call/return: call at fetch_pc=0, target=10 → ras_count=1, fetch 10,11. ret_valid at fetch_pc=11 → one bubble, then fetch_pc=1, ras_count=0.
- RAS boundaries, RAS_DEPTH=4:
  - 5 nested calls at PCs 0, 20, 30, 40, 50 → ras_count=4.
  - 4 returns → targets 51, 41, 31, 21.
  - 5th return → target 0, ras_underflow pulses 1 cycle.
- Reset mid-op and wrap:
  - rst_n=0 during KILL with ras_count=2 → next cycle fetch_valid=0, imem_addr=RESET_PC, ras_count=0.
  - RESET_PC=16'hFFFF → fetch_pc FFFF then 0000.
